// File: rtl/conv_pkg.sv
// Shared constants, address-width helper, port-slice helper and window update
// encoding for the convolution-core window register file and MAC-array blocks.
package conv_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 5;
  localparam int DEF_NUM_RD = 2;

  // Window update applied on a clock edge; a load always wins over a shift.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_SHIFT
  } updOp_t;

  function automatic int addrBits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // LSB of port k's slice in a flat bus of per-port fields of width w.
  function automatic int sliceLsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the window register file: entry mux, range
// check and the valid/error strobes, all with one cycle of latency.
module rf_read_port
  import conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = addrBits(DEF_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdEn,
  input  logic [ADDR-1:0]        address,
  input  logic [DEPTH*WIDTH-1:0] entries,
  output logic [WIDTH-1:0]       rdData,
  output logic                   rdValid,
  output logic                   rdErr
);

  logic [WIDTH-1:0] selData;
  logic             outOfRange;

  always_comb begin
    selData    = '0;
    outOfRange = (int'(address) >= DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(address) == i) selData = entries[i*WIDTH +: WIDTH];
    end
  end

  // Data and error flag only move on a request; idle cycles hold the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdData  <= '0;
      rdValid <= 1'b0;
      rdErr   <= 1'b0;
    end else begin
      rdValid <= rdEn;
      if (rdEn) begin
        rdData <= outOfRange ? '0 : selData;
        rdErr  <= outOfRange;
      end
    end
  end

endmodule

// File: rtl/conv_window_regfile.sv
// Kernel-row window store with parallel load, sliding shift and NUM_RD
// registered read ports. Define RF_BYPASS_EN for write-through read forwarding.
module conv_window_regfile
  import conv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR   = addrBits(DEF_DEPTH),
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrEn,
  input  logic                    shiftEn,
  input  logic [DEPTH*WIDTH-1:0]  WrData,
  input  logic [WIDTH-1:0]        ShiftData,
  input  logic [NUM_RD-1:0]       RdEn,
  input  logic [NUM_RD*ADDR-1:0]  Address,
  output logic [NUM_RD*WIDTH-1:0] RdData,
  output logic [NUM_RD-1:0]       RdData_valid,
  output logic [NUM_RD-1:0]       RdErr,
  output logic                    window_full
);

  logic [DEPTH-1:0][WIDTH-1:0] entry;
  logic [DEPTH-1:0][WIDTH-1:0] nextEntry;
  logic [DEPTH-1:0]            validBits;
  logic [DEPTH-1:0]            nextValid;
  logic [DEPTH*WIDTH-1:0]      readView;
  updOp_t                      op;

  // Entry 0 is the oldest pixel; a shift drops it and appends at the top.
  always_comb begin
    op        = UPD_HOLD;
    nextEntry = entry;
    nextValid = validBits;
    if (wrEn)         op = UPD_LOAD;
    else if (shiftEn) op = UPD_SHIFT;
    case (op)
      UPD_LOAD: begin
        nextEntry = WrData;
        nextValid = '1;
      end
      UPD_SHIFT: begin
        nextEntry = {ShiftData, entry[DEPTH-1:1]};
        nextValid = {1'b1, validBits[DEPTH-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry       <= '0;
      validBits   <= '0;
      window_full <= 1'b0;
    end else begin
      entry       <= nextEntry;
      validBits   <= nextValid;
      window_full <= &nextValid;
    end
  end

`ifdef RF_BYPASS_EN
  assign readView = nextEntry;
`else
  assign readView = entry;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : gRdPort
    rf_read_port #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .ADDR (ADDR)
    ) uRdPort (
      .clk    (clk),
      .rst    (rst),
      .rdEn   (RdEn[k]),
      .address(Address[sliceLsb(k, ADDR) +: ADDR]),
      .entries(readView),
      .rdData (RdData[sliceLsb(k, WIDTH) +: WIDTH]),
      .rdValid(RdData_valid[k]),
      .rdErr  (RdErr[k])
    );
  end

endmodule

// File: tb/tb_conv_window_regfile.sv
// Directed self-checking bench for conv_window_regfile (default parameters).
module tb_conv_window_regfile;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 5;
  localparam int ADDR   = 3;
  localparam int NUM_RD = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wrEn;
  logic                    shiftEn;
  logic [DEPTH*WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]        ShiftData;
  logic [NUM_RD-1:0]       RdEn;
  logic [NUM_RD*ADDR-1:0]  Address;
  logic [NUM_RD*WIDTH-1:0] RdData;
  logic [NUM_RD-1:0]       RdData_valid;
  logic [NUM_RD-1:0]       RdErr;
  logic                    window_full;

  int nAsserts = 0;
  int nFails   = 0;
  logic [WIDTH-1:0] expBypass;

  conv_window_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wrEn        (wrEn),
    .shiftEn     (shiftEn),
    .WrData      (WrData),
    .ShiftData   (ShiftData),
    .RdEn        (RdEn),
    .Address     (Address),
    .RdData      (RdData),
    .RdData_valid(RdData_valid),
    .RdErr       (RdErr),
    .window_full (window_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_RD-1:0] en, input logic [ADDR-1:0] a0,
                               input logic [ADDR-1:0] a1);
    RdEn    = en;
    Address = {a1, a0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; shiftEn = 1'b0; WrData = '0; ShiftData = '0;
    applyStimulus(2'b00, 3'd0, 3'd0);
    tick(); tick();
    checkOutput("initRdData", 32'(RdData), 32'd0);
    checkOutput("initFull", 32'(window_full), 32'd0);
    rst = 1'b0;

    // Parallel load, then sweep every address on port 0 back-to-back
    wrEn = 1'b1;
    WrData = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    wrEn = 1'b0;
    checkOutput("loadFull", 32'(window_full), 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(2'b01, ADDR'(a), 3'd0);
      tick();
      checkOutput("loadRdData", 32'(RdData[7:0]), 32'(a + 1));
      checkOutput("loadRdValid", 32'(RdData_valid), 32'd1);
      checkOutput("loadRdErr", 32'(RdErr[0]), 32'd0);
    end
    applyStimulus(2'b00, 3'd0, 3'd0);
    tick();
    checkOutput("idleValid", 32'(RdData_valid), 32'd0);
    checkOutput("idleHold", 32'(RdData[7:0]), 32'd5);

    // Both ports, one in range and one out of range
    applyStimulus(2'b11, 3'd2, 3'd7);
    tick();
    checkOutput("dualP0Data", 32'(RdData[7:0]), 32'd3);
    checkOutput("dualP1Data", 32'(RdData[15:8]), 32'd0);
    checkOutput("dualValid", 32'(RdData_valid), 32'd3);
    checkOutput("dualErr", 32'(RdErr), 32'd2);

    // Reset held two cycles in the middle of read and shift traffic
    applyStimulus(2'b11, 3'd4, 3'd7);
    shiftEn = 1'b1; ShiftData = 8'd33; rst = 1'b1;
    tick(); tick();
    checkOutput("rstRdData", 32'(RdData), 32'd0);
    checkOutput("rstValid", 32'(RdData_valid), 32'd0);
    checkOutput("rstErr", 32'(RdErr), 32'd0);
    checkOutput("rstFull", 32'(window_full), 32'd0);
    rst = 1'b0; shiftEn = 1'b0;
    applyStimulus(2'b01, 3'd4, 3'd0);
    tick();
    checkOutput("unwrittenData", 32'(RdData[7:0]), 32'd0);
    checkOutput("unwrittenErr", 32'(RdErr[0]), 32'd0);
    applyStimulus(2'b00, 3'd0, 3'd0);

    // Fill by shifting; full only after the fifth shift
    for (int i = 0; i < DEPTH; i++) begin
      shiftEn = 1'b1; ShiftData = WIDTH'((i + 1) * 10);
      tick();
      checkOutput("shiftFull", 32'(window_full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    shiftEn = 1'b0;
    applyStimulus(2'b11, 3'd0, 3'd4);
    tick();
    checkOutput("shiftAddr0", 32'(RdData[7:0]), 32'd10);
    checkOutput("shiftAddr4", 32'(RdData[15:8]), 32'd50);
    applyStimulus(2'b00, 3'd0, 3'd0);
    shiftEn = 1'b1; ShiftData = 8'd60;
    tick();
    shiftEn = 1'b0;
    applyStimulus(2'b11, 3'd0, 3'd4);
    tick();
    checkOutput("shift6Addr0", 32'(RdData[7:0]), 32'd20);
    checkOutput("shift6Addr4", 32'(RdData[15:8]), 32'd60);
    applyStimulus(2'b11, 3'd3, 3'd3);
    tick();
    checkOutput("sameAddrP0", 32'(RdData[7:0]), 32'd50);
    checkOutput("sameAddrP1", 32'(RdData[15:8]), 32'd50);
    applyStimulus(2'b00, 3'd0, 3'd0);

    // Load and shift together: the load wins
    wrEn = 1'b1; shiftEn = 1'b1;
    WrData = {5{8'd9}}; ShiftData = 8'd77;
    tick();
    wrEn = 1'b0; shiftEn = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(2'b01, ADDR'(a), 3'd0);
      tick();
      checkOutput("loadWinsData", 32'(RdData[7:0]), 32'd9);
    end
    applyStimulus(2'b00, 3'd0, 3'd0);
    tick();

    // Read coincident with a shift
`ifdef RF_BYPASS_EN
    expBypass = 8'd88;
`else
    expBypass = 8'd9;
`endif
    shiftEn = 1'b1; ShiftData = 8'd88;
    applyStimulus(2'b11, 3'd4, 3'd5);
    tick();
    shiftEn = 1'b0;
    applyStimulus(2'b00, 3'd0, 3'd0);
    checkOutput("coincidentRead", 32'(RdData[7:0]), 32'(expBypass));
    checkOutput("coincidentErr", 32'(RdErr), 32'd2);
    applyStimulus(2'b01, 3'd4, 3'd0);
    tick();
    checkOutput("afterShiftRead", 32'(RdData[7:0]), 32'd88);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
